mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store engine on the consuming side of the EX/MEM pipeline register. It takes the ALU address, the store data and the read_write code, and runs one request/acknowledge transaction with a multi-cycle data memory. It formats byte enables and store lanes, aligns and extends load data, and stalls the pipeline until the access completes.

Parameters:
ADDR_WIDTH, 32, width of the byte address and of mem_addr
DATA_WIDTH, 32, data bus width; fixed at 32 for RV32, no other value is supported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
alu_result_mem_in  input  32  byte address from the EX/MEM register
read_data2_mem_in  input  32  store data from the EX/MEM register
read_write_mem_in  input  4  memory op code (see Behaviour)
mem_req  output  1  request to data memory; held until acknowledged
mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-positioned store data
mem_rdata  input  32  read data; sampled only in the mem_ack cycle
mem_ack  input  1  one-cycle completion pulse from memory
load_data_out  output  32  aligned and extended load result
stall_out  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high
done_out  output  1  one-cycle pulse when an access completes
misaligned_out  output  1  misaligned-access flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Op codes, read_write[3:0]:
  - NOP 0000
  - SB 0100, SH 0101, SW 0110
  - LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101
  - All other codes are treated as NOP.
- Misalignment: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 is misaligned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - A valid, aligned op asserts stall_out combinationally.
  - At the clock edge the FSM latches op, address, store data and byte offset, then enters BUSY.
- BUSY:
  - mem_req=1 (registered) and stall_out=1.
  - mem_addr, mem_we, mem_be and mem_wdata stay constant until mem_ack.
  - On mem_ack: for a load, latch the formatted mem_rdata into load_data_out; go to DONE. mem_req drops in the next cycle.
- DONE:
  - stall_out=0 and done_out=1 for exactly one cycle.
  - Always returns to IDLE. The op present on the inputs during DONE is ignored, because it is the completed op while the pipeline advances.
- Latency: with ack in the first BUSY cycle, the op is presented at cycle 0, mem_req rises at cycle 1, ack arrives at cycle 1, and done_out fires at cycle 2. Each extra wait cycle adds one cycle.
- Store formatting:
  - SB: byte replicated to all four lanes, be = 0001 << addr[1:0].
  - SH: halfword replicated, be = 0011 << {addr[1],1'b0}.
  - SW: be = 1111.
- Load formatting:
  - Select the byte or halfword by the latched offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Misaligned op in IDLE:
  - misaligned_out=1 combinationally; no request is issued; stall_out=0; load_data_out is unchanged.
- NOP in IDLE: no activity; all strobes are 0.
- mem_ack outside BUSY is ignored.
- Reset values (also apply on reset mid-transaction, asynchronously):
  - state IDLE; mem_req, mem_we, done_out 0.
  - mem_be 0, mem_addr 0, mem_wdata 0, load_data_out 0.
  - Reset during BUSY abandons the access; no done_out is produced.
- load_data_out holds its value until the next completed load. Stores do not change it.

Decomposition:
- Add to the shared encodings include:
  - MEM_NOP, MEM_SB/SH/SW and MEM_LB/LH/LW/LBU/LHU constants.
  - FSM state constants MEM_IDLE, MEM_BUSY, MEM_DONE.
- One combinational sub-module, load_aligner. Inputs: rdata, offset, op. Output: 32-bit formatted load value.
- Store lane and byte-enable generation stays inline.

Test Plan:
- LW, addr 0x00000104, ack after 2 wait cycles, rdata 0xDEADBEEF:
  - mem_addr=0x104, be=1111, we=0.
  - stall_out high for 4 cycles; done_out pulses.
  - load_data_out=0xDEADBEEF.
- LB then LBU, addr 0x203, rdata 0x80FF1234:
  - LB: load_data_out=0xFFFFFF80.
  - LBU: load_data_out=0x00000080.
  - LH at 0x202 gives 0xFFFF80FF.
- SB, addr 0x11, data 0x000000A5:
  - mem_we=1, be=0010, wdata=0xA5A5A5A5, mem_addr=0x10.
  - load_data_out unchanged.
- SH at 0x2 with data 0x1234 -> be=1100, wdata=0x12341234.
- LW at 0x102 -> misaligned_out=1, mem_req stays 0, stall_out=0.
- Reset asserted in BUSY cycle 2, before ack:
  - mem_req and stall_out drop immediately; no done_out.
  - A later ack is ignored; the next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: op codes, FSM states
// and small decode helpers used by the top and the load aligner.
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_NOP = 4'b0000;
    localparam logic [3:0] MEM_SB  = 4'b0100;
    localparam logic [3:0] MEM_SH  = 4'b0101;
    localparam logic [3:0] MEM_SW  = 4'b0110;
    localparam logic [3:0] MEM_LB  = 4'b1000;
    localparam logic [3:0] MEM_LH  = 4'b1001;
    localparam logic [3:0] MEM_LW  = 4'b1010;
    localparam logic [3:0] MEM_LBU = 4'b1100;
    localparam logic [3:0] MEM_LHU = 4'b1101;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_BUSY = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // Unrecognised codes decode to SZ_NONE and therefore behave as NOP.
    function automatic mem_size_e op_size(input logic [3:0] op);
        mem_size_e sz;
        case (op)
            MEM_SB, MEM_LB, MEM_LBU: sz = SZ_BYTE;
            MEM_SH, MEM_LH, MEM_LHU: sz = SZ_HALF;
            MEM_SW, MEM_LW:          sz = SZ_WORD;
            MEM_NOP:                 sz = SZ_NONE;
            default:                 sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it according to the load op; LW passes through.
module load_aligner
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            MEM_LB:  data_out = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_out = {24'h000000, byte_sel};
            MEM_LH:  data_out = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_out = {16'h0000, half_sel};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack transaction per op with a
// multi-cycle data memory, stalling the pipeline until the access completes.
//
// state     | meaning
// MEM_IDLE  | waiting for a valid aligned op; stall raised combinationally
// MEM_BUSY  | mem_req held, outputs frozen until mem_ack
// MEM_DONE  | one-cycle done_out, pipeline released, inputs ignored
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   alu_result_mem_in,
    input  logic [DATA_WIDTH-1:0]   read_data2_mem_in,
    input  logic [3:0]              read_write_mem_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [3:0]              mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic [DATA_WIDTH-1:0]   load_data_out,
    output logic                    stall_out,
    output logic                    done_out,
    output logic                    misaligned_out
);

    logic [1:0]            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;

    mem_size_e             size_in;
    logic                  misaligned;
    logic                  start;
    logic [3:0]            be_fmt;
    logic [DATA_WIDTH-1:0] wdata_fmt;
    logic [DATA_WIDTH-1:0] load_fmt;

    load_aligner u_load_aligner (
        .rdata    (mem_rdata),
        .offset   (off_q),
        .op       (op_q),
        .data_out (load_fmt)
    );

    always_comb begin
        size_in    = op_size(read_write_mem_in);
        misaligned = ((size_in == SZ_HALF) && alu_result_mem_in[0]) ||
                     ((size_in == SZ_WORD) && (alu_result_mem_in[1:0] != 2'b00));
        start      = (state_q == MEM_IDLE) && (size_in != SZ_NONE) && !misaligned;

        be_fmt    = 4'b0000;
        wdata_fmt = '0;
        case (size_in)
            SZ_BYTE: begin
                be_fmt    = 4'b0001 << alu_result_mem_in[1:0];
                wdata_fmt = {4{read_data2_mem_in[7:0]}};
            end
            SZ_HALF: begin
                be_fmt    = 4'b0011 << {alu_result_mem_in[1], 1'b0};
                wdata_fmt = {2{read_data2_mem_in[15:0]}};
            end
            SZ_WORD: begin
                be_fmt    = 4'b1111;
                wdata_fmt = read_data2_mem_in;
            end
            default: begin
                be_fmt    = 4'b0000;
                wdata_fmt = '0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        load_d  = load_q;
        case (state_q)
            MEM_IDLE: begin
                if (start) begin
                    state_d = MEM_BUSY;
                    req_d   = 1'b1;
                    we_d    = op_is_store(read_write_mem_in);
                    be_d    = be_fmt;
                    addr_d  = {alu_result_mem_in[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = wdata_fmt;
                    op_d    = read_write_mem_in;
                    off_d   = alu_result_mem_in[1:0];
                end
            end
            MEM_BUSY: begin
                if (mem_ack) begin
                    state_d = MEM_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    if (op_is_load(op_q)) begin
                        load_d = load_fmt;
                    end
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= MEM_NOP;
            off_q   <= 2'b00;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
            load_q  <= load_d;
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_be         = be_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign load_data_out  = load_q;
    assign done_out       = (state_q == MEM_DONE);
    assign misaligned_out = (state_q == MEM_IDLE) && misaligned;
    // Gated by rst so an abandoned access releases the pipeline at once.
    assign stall_out      = !rst && (start || (state_q == MEM_BUSY));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// ops checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] SB  = 4'b0100;
    localparam logic [3:0] SH  = 4'b0101;
    localparam logic [3:0] SW  = 4'b0110;
    localparam logic [3:0] LB  = 4'b1000;
    localparam logic [3:0] LH  = 4'b1001;
    localparam logic [3:0] LW  = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100;
    localparam logic [3:0] LHU = 4'b1101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  op_in = NOP;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] load_data_out;
    logic        stall_out, done_out, misaligned_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_load = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_result_mem_in (addr_in),
        .read_data2_mem_in (data_in),
        .read_write_mem_in (op_in),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_be            (mem_be),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .load_data_out     (load_data_out),
        .stall_out         (stall_out),
        .done_out          (done_out),
        .misaligned_out    (misaligned_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [3:0] op);
        if (op == SB || op == LB || op == LBU) return 1;
        if (op == SH || op == LH || op == LHU) return 2;
        if (op == SW || op == LW) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (size_of(op) == 1) begin
            v = v & 32'hFF;
            if (op == LB && v >= 128) v = v - 256;
        end else if (size_of(op) == 2) begin
            v = v & 32'hFFFF;
            if (op == LH && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int waits);
        int          sz;
        int          stalls;
        logic        st;
        logic [3:0]  be;
        logic [31:0] wd;
        sz     = size_of(op);
        st     = (op == SB || op == SH || op == SW);
        stalls = 0;
        be     = (sz == 4) ? 4'hF : (sz == 2) ? 4'(3 << (addr % 4)) : 4'(1 << (addr % 4));
        wd     = (sz == 1) ? data[7:0] * 32'h01010101 :
                 (sz == 2) ? data[15:0] * 32'h00010001 : data;
        op_in = op; addr_in = addr; data_in = data; mem_ack = 1'b0;
        #1;
        chk("start_stall", 32'(stall_out), 1);
        chk("start_misaligned", 32'(misaligned_out), 0);
        chk("start_req", 32'(mem_req), 0);
        if (stall_out) stalls++;
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            if (stall_out) stalls++;
            chk("busy_req", 32'(mem_req), 1);
            chk("busy_addr", mem_addr, {addr[31:2], 2'b00});
            chk("busy_we", 32'(mem_we), 32'(st));
            chk("busy_be", 32'(mem_be), 32'(be));
            if (st) chk("busy_wdata", mem_wdata, wd);
            chk("busy_done", 32'(done_out), 0);
            mem_ack   = (w == waits);
            mem_rdata = (w == waits) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!st) exp_load = model_load(op, addr, rdata);
        chk("done_pulse", 32'(done_out), 1);
        chk("done_stall", 32'(stall_out), 0);
        chk("done_req", 32'(mem_req), 0);
        chk("stall_cycles", 32'(stalls), 32'(waits + 2));
        chk("load_data", load_data_out, exp_load);
        @(posedge clk); #1;
        op_in = NOP;
        #1;
        chk("after_done", 32'(done_out), 0);
        chk("after_req", 32'(mem_req), 0);
    endtask

    task automatic misaligned_step(input logic [3:0] op, input logic [31:0] addr);
        op_in = op; addr_in = addr; data_in = $urandom;
        #1;
        chk("mis_flag", 32'(misaligned_out), 1);
        chk("mis_stall", 32'(stall_out), 0);
        @(posedge clk); #1;
        chk("mis_req", 32'(mem_req), 0);
        chk("mis_done", 32'(done_out), 0);
        chk("mis_load", load_data_out, exp_load);
        op_in = NOP;
        #1;
        chk("mis_clear", 32'(misaligned_out), 0);
    endtask

    task automatic idle_step(input logic [3:0] op);
        op_in = op; addr_in = $urandom; data_in = $urandom;
        mem_ack = 1'b1; mem_rdata = $urandom;
        #1;
        chk("nop_stall", 32'(stall_out), 0);
        chk("nop_misaligned", 32'(misaligned_out), 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("nop_req", 32'(mem_req), 0);
        chk("nop_be", 32'(mem_be), 0);
        chk("nop_done", 32'(done_out), 0);
        chk("nop_load", load_data_out, exp_load);
        op_in = NOP;
    endtask

    initial begin
        logic [3:0]  ops [12];
        logic [3:0]  op;
        logic [31:0] a;
        int          sz;
        ops = '{NOP, SB, SH, SW, LB, LH, LW, LBU, LHU, 4'b0111, 4'b1111, 4'b0011};

        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_load", load_data_out, 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_stall", 32'(stall_out), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        access(LW, 32'h00000104, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_value", load_data_out, 32'hDEADBEEF);
        access(LB, 32'h00000203, 32'h0, 32'h80FF1234, 0);
        chk("lb_value", load_data_out, 32'hFFFFFF80);
        access(LBU, 32'h00000203, 32'h0, 32'h80FF1234, 1);
        chk("lbu_value", load_data_out, 32'h00000080);
        access(LH, 32'h00000202, 32'h0, 32'h80FF1234, 0);
        chk("lh_value", load_data_out, 32'hFFFF80FF);
        access(SB, 32'h00000011, 32'h000000A5, 32'h12345678, 0);
        chk("sb_load_kept", load_data_out, 32'hFFFF80FF);
        access(SH, 32'h00000002, 32'h00001234, 32'h0, 1);
        misaligned_step(LW, 32'h00000102);
        idle_step(NOP);

        // Reset in the second BUSY cycle, before any ack.
        op_in = LW; addr_in = 32'h00000300;
        @(posedge clk); #1;
        chk("rbusy1_req", 32'(mem_req), 1);
        @(posedge clk); #1;
        chk("rbusy2_req", 32'(mem_req), 1);
        rst = 1'b1;
        #1;
        exp_load = '0;
        chk("rmid_req", 32'(mem_req), 0);
        chk("rmid_stall", 32'(stall_out), 0);
        chk("rmid_done", 32'(done_out), 0);
        chk("rmid_load", load_data_out, exp_load);
        op_in = NOP;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_done", 32'(done_out), 0);
        chk("late_ack_req", 32'(mem_req), 0);
        chk("late_ack_load", load_data_out, exp_load);
        access(LW, 32'h00000300, 32'h0, 32'h0BADF00D, 1);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 11)];
            a  = $urandom;
            sz = size_of(op);
            if (sz == 0) begin
                idle_step(op);
            end else begin
                if ($urandom_range(0, 1) == 1) a = a & ~32'(sz - 1);
                if ((a % sz) != 0) misaligned_step(op, a);
                else access(op, a, $urandom, $urandom, $urandom_range(0, 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
